// File: rtl/vic_bus_scheduler.sv
// PAL 6569 bus-cycle scheduler: tracks cycle/raster and decides the VIC phi1/phi2
// memory access, BA/AEC bus arbitration and the frame-start pulse for every cycle.
module vic_bus_scheduler #(
  parameter int CYCLES_PER_LINE = 63,
  parameter int LINES_PER_FRAME = 312,
  parameter int FIRST_DMA_LINE  = 48,
  parameter int LAST_DMA_LINE   = 247,
  parameter int BA_LEAD         = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_cycle_tick,
  input  logic       i_den,
  input  logic [2:0] i_yscroll,
  input  logic [7:0] i_sprite_dma,
  output logic [5:0] o_cycle,
  output logic [8:0] o_raster,
  output logic       o_badline,
  output logic       o_ba,
  output logic       o_aec,
  output logic [2:0] o_phi1_acc,
  output logic [2:0] o_phi2_acc,
  output logic [2:0] o_sprite_idx,
  output logic       o_frame_start
);

  typedef enum logic [2:0] {
    ACC_IDLE     = 3'd0,
    ACC_REFRESH  = 3'd1,
    ACC_CHAR     = 3'd2,
    ACC_GFX      = 3'd3,
    ACC_SPR_PTR  = 3'd4,
    ACC_SPR_DATA = 3'd5
  } acc_e;

  localparam logic [5:0] LAST_CYCLE  = 6'(CYCLES_PER_LINE);
  localparam logic [8:0] LAST_RASTER = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] DMA_FIRST   = 9'(FIRST_DMA_LINE);
  localparam logic [8:0] DMA_LAST    = 9'(LAST_DMA_LINE);

  // Sprite pointer cycle P(n); sprites 3..7 fall at the start of the next line.
  function automatic logic [5:0] p_cycle(input logic [2:0] n);
    case (n)
      3'd0:    p_cycle = 6'd58;
      3'd1:    p_cycle = 6'd60;
      3'd2:    p_cycle = 6'd62;
      3'd3:    p_cycle = 6'd1;
      3'd4:    p_cycle = 6'd3;
      3'd5:    p_cycle = 6'd5;
      3'd6:    p_cycle = 6'd7;
      default: p_cycle = 6'd9;
    endcase
  endfunction

  function automatic logic char_steal(input logic [5:0] cyc, input logic bl);
    char_steal = bl && (cyc >= 6'd15) && (cyc <= 6'd54);
  endfunction

  function automatic logic phi2_steal(input logic [5:0] cyc, input logic bl,
                                      input logic [7:0] dma);
    phi2_steal = char_steal(cyc, bl);
    for (int n = 0; n < 8; n++) begin
      if (dma[n] && ((cyc == p_cycle(3'(n))) || (cyc == p_cycle(3'(n)) + 6'd1)))
        phi2_steal = 1'b1;
    end
  endfunction

  // BA must drop BA_LEAD cycles ahead of any steal, looking across the line end.
  function automatic logic ba_low(input logic [5:0] cyc, input logic bl,
                                  input logic [7:0] dma);
    logic [6:0] c;
    ba_low = 1'b0;
    for (int k = 0; k <= BA_LEAD; k++) begin
      c = 7'(cyc) + 7'(k);
      if (c > 7'(CYCLES_PER_LINE)) c = c - 7'(CYCLES_PER_LINE);
      if (phi2_steal(6'(c), bl, dma)) ba_low = 1'b1;
    end
  endfunction

  logic [5:0] cycle_q, cycle_d;
  logic [8:0] raster_q, raster_d;
  logic       den_latch_q, den_latch_d;
  logic       display_q, display_d;
  logic       badline_q, badline_d;
  logic       ba_q, ba_d;
  logic       aec_q, aec_d;
  acc_e       phi1_q, phi1_d;
  acc_e       phi2_q, phi2_d;
  logic [2:0] sprite_idx_q, sprite_idx_d;
  logic       frame_start_q, frame_start_d;
  logic       line_wrap, frame_wrap;

  always_comb begin
    // NOTE: every comb output gets its hold value first so no path infers a latch.
    cycle_d       = cycle_q;
    raster_d      = raster_q;
    den_latch_d   = den_latch_q;
    display_d     = display_q;
    badline_d     = badline_q;
    ba_d          = ba_q;
    aec_d         = aec_q;
    phi1_d        = phi1_q;
    phi2_d        = phi2_q;
    sprite_idx_d  = sprite_idx_q;
    frame_start_d = 1'b0;
    line_wrap     = (cycle_q == LAST_CYCLE);
    frame_wrap    = line_wrap && (raster_q == LAST_RASTER);

    if (i_cycle_tick) begin
      cycle_d  = line_wrap ? 6'd1 : cycle_q + 6'd1;
      raster_d = frame_wrap ? 9'd0 : (line_wrap ? raster_q + 9'd1 : raster_q);

      den_latch_d = frame_wrap ? 1'b0
                  : (den_latch_q | (i_den && (raster_d == DMA_FIRST)));
      badline_d   = den_latch_d && (raster_d >= DMA_FIRST) && (raster_d <= DMA_LAST)
                    && (raster_d[2:0] == i_yscroll);
      display_d   = (frame_wrap || (raster_d > DMA_LAST)) ? 1'b0
                  : (display_q | badline_d);

      phi1_d       = ACC_IDLE;
      sprite_idx_d = 3'd0;
      if (cycle_d >= 6'd11 && cycle_d <= 6'd15)
        phi1_d = ACC_REFRESH;
      else if (cycle_d >= 6'd16 && cycle_d <= 6'd55 && display_d)
        phi1_d = ACC_GFX;
      for (int n = 0; n < 8; n++) begin
        if (cycle_d == p_cycle(3'(n))) begin
          phi1_d       = ACC_SPR_PTR;
          sprite_idx_d = 3'(n);
        end else if (cycle_d == p_cycle(3'(n)) + 6'd1) begin
          phi1_d       = i_sprite_dma[n] ? ACC_SPR_DATA : ACC_IDLE;
          sprite_idx_d = 3'(n);
        end
      end

      if (char_steal(cycle_d, badline_d))
        phi2_d = ACC_CHAR;
      else if (phi2_steal(cycle_d, 1'b0, i_sprite_dma))
        phi2_d = ACC_SPR_DATA;
      else
        phi2_d = ACC_IDLE;

      aec_d         = (phi2_d == ACC_IDLE);
      ba_d          = !ba_low(cycle_d, badline_d, i_sprite_dma);
      frame_start_d = frame_wrap;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q       <= 6'd1;
      raster_q      <= 9'd0;
      den_latch_q   <= 1'b0;
      display_q     <= 1'b0;
      badline_q     <= 1'b0;
      ba_q          <= 1'b1;
      aec_q         <= 1'b1;
      phi1_q        <= ACC_IDLE;
      phi2_q        <= ACC_IDLE;
      sprite_idx_q  <= 3'd0;
      frame_start_q <= 1'b0;
    end else begin
      cycle_q       <= cycle_d;
      raster_q      <= raster_d;
      den_latch_q   <= den_latch_d;
      display_q     <= display_d;
      badline_q     <= badline_d;
      ba_q          <= ba_d;
      aec_q         <= aec_d;
      phi1_q        <= phi1_d;
      phi2_q        <= phi2_d;
      sprite_idx_q  <= sprite_idx_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_cycle       = cycle_q;
  assign o_raster      = raster_q;
  assign o_badline     = badline_q;
  assign o_ba          = ba_q;
  assign o_aec         = aec_q;
  assign o_phi1_acc    = phi1_q;
  assign o_phi2_acc    = phi2_q;
  assign o_sprite_idx  = sprite_idx_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vic_bus_scheduler.sv
// Directed bench for vic_bus_scheduler: reset, badline, sprite windows, frame wrap
// and asynchronous reset, with expected values written out by hand.
module tb_vic_bus_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_cycle_tick;
  logic       i_den;
  logic [2:0] i_yscroll;
  logic [7:0] i_sprite_dma;
  logic [5:0] o_cycle;
  logic [8:0] o_raster;
  logic       o_badline, o_ba, o_aec, o_frame_start;
  logic [2:0] o_phi1_acc, o_phi2_acc, o_sprite_idx;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cycle, exp_raster;
  logic seen_bad;

  always #5 clk = ~clk;

  vic_bus_scheduler dut (
    .clk          (clk),
    .reset        (rst_n),
    .i_cycle_tick (i_cycle_tick),
    .i_den        (i_den),
    .i_yscroll    (i_yscroll),
    .i_sprite_dma (i_sprite_dma),
    .o_cycle      (o_cycle),
    .o_raster     (o_raster),
    .o_badline    (o_badline),
    .o_ba         (o_ba),
    .o_aec        (o_aec),
    .o_phi1_acc   (o_phi1_acc),
    .o_phi2_acc   (o_phi2_acc),
    .o_sprite_idx (o_sprite_idx),
    .o_frame_start(o_frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (raster %0d cycle %0d)",
               tag, got, exp, exp_raster, exp_cycle);
    end
  endtask

  // One bus-cycle tick; returns at the next negedge with the new cycle's outputs.
  task automatic tick();
    i_cycle_tick = 1'b1;
    @(negedge clk);
    i_cycle_tick = 1'b0;
    if (exp_cycle == 63) begin
      exp_cycle  = 1;
      exp_raster = (exp_raster == 311) ? 0 : exp_raster + 1;
    end else begin
      exp_cycle = exp_cycle + 1;
    end
    seen_bad = seen_bad | o_badline;
  endtask

  task automatic run_to(input int r, input int c);
    while (!(exp_raster == r && exp_cycle == c)) tick();
    check("pos_raster", o_raster, r);
    check("pos_cycle", o_cycle, c);
  endtask

  function automatic int exp_phi1_plain(input int c, input logic disp);
    if (c == 58 || c == 60 || c == 62 || c == 1 || c == 3 || c == 5 || c == 7 || c == 9)
      return 4;
    if (c >= 11 && c <= 15) return 1;
    if (c >= 16 && c <= 55 && disp) return 3;
    return 0;
  endfunction

  initial begin
    rst_n        = 1'b0;
    i_cycle_tick = 1'b0;
    i_den        = 1'b0;
    i_yscroll    = 3'd0;
    i_sprite_dma = 8'h00;
    exp_cycle    = 1;
    exp_raster   = 0;
    seen_bad     = 1'b0;

    // Reset, released with no ticks.
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cycle", o_cycle, 1);
    check("rst_raster", o_raster, 0);
    check("rst_ba", o_ba, 1);
    check("rst_aec", o_aec, 1);
    check("rst_phi1", o_phi1_acc, 0);
    check("rst_phi2", o_phi2_acc, 0);
    check("rst_badline", o_badline, 0);
    check("rst_fstart", o_frame_start, 0);
    check("rst_idx", o_sprite_idx, 0);

    // Outputs hold while no tick arrives.
    run_to(5, 20);
    repeat (4) @(negedge clk);
    check("hold_cycle", o_cycle, 20);
    check("hold_raster", o_raster, 5);

    // Sprite 0 DMA on a non-badline.
    run_to(10, 1);
    i_sprite_dma = 8'h01;
    for (int c = 2; c <= 63; c++) begin
      tick();
      check("spr0_ba", o_ba, (c >= 55 && c <= 59) ? 0 : 1);
      if (c == 58 || c == 59) begin
        check("spr0_phi1", o_phi1_acc, (c == 58) ? 4 : 5);
        check("spr0_phi2", o_phi2_acc, 5);
        check("spr0_aec", o_aec, 0);
        check("spr0_idx", o_sprite_idx, 0);
      end
      if (c == 60) begin
        check("spr1_ptr_phi1", o_phi1_acc, 4);
        check("spr1_ptr_idx", o_sprite_idx, 1);
        check("spr1_ptr_phi2", o_phi2_acc, 0);
      end
    end
    tick();
    i_sprite_dma = 8'h00;

    // Sprite 3 DMA: BA window crosses the line end.
    run_to(20, 10);
    i_sprite_dma = 8'h08;
    while (!(exp_raster == 21 && exp_cycle == 3)) begin
      tick();
      if (exp_raster == 20)
        check("spr3_ba_k", o_ba, (exp_cycle >= 61) ? 0 : 1);
      else
        check("spr3_ba_k1", o_ba, (exp_cycle <= 2) ? 0 : 1);
      if (exp_raster == 21 && exp_cycle <= 2) begin
        check("spr3_phi2", o_phi2_acc, 5);
        check("spr3_idx", o_sprite_idx, 3);
        check("spr3_phi1", o_phi1_acc, (exp_cycle == 1) ? 4 : 5);
      end
    end
    check("spr3_end_phi2", o_phi2_acc, 0);
    i_sprite_dma = 8'h00;

    // den low through line 48, high afterwards: no badline this frame.
    run_to(47, 63);
    seen_bad = 1'b0;
    run_to(49, 1);
    i_den = 1'b1;
    run_to(311, 63);
    check("no_badline_frame", seen_bad, 0);
    check("pre_wrap_fstart", o_frame_start, 0);
    tick();
    check("wrap_raster", o_raster, 0);
    check("wrap_cycle", o_cycle, 1);
    check("wrap_fstart", o_frame_start, 1);
    @(negedge clk);
    check("fstart_pulse_end", o_frame_start, 0);

    // Frame 1: den high on line 48, yscroll 0 -> line 48 is a badline.
    run_to(47, 63);
    for (int c = 1; c <= 63; c++) begin
      tick();
      check("bl_badline", o_badline, 1);
      check("bl_ba", o_ba, (c >= 12 && c <= 54) ? 0 : 1);
      check("bl_phi2", o_phi2_acc, (c >= 15 && c <= 54) ? 2 : 0);
      check("bl_aec", o_aec, (c >= 15 && c <= 54) ? 0 : 1);
      check("bl_phi1", o_phi1_acc, exp_phi1_plain(c, 1'b1));
    end
    for (int c = 1; c <= 63; c++) begin
      tick();
      check("l49_ba", o_ba, 1);
      check("l49_badline", o_badline, 0);
      check("l49_phi1", o_phi1_acc, exp_phi1_plain(c, 1'b1));
    end

    // Asynchronous reset mid-badline, between clock edges.
    run_to(56, 30);
    check("bl56_ba", o_ba, 0);
    check("bl56_phi2", o_phi2_acc, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ba", o_ba, 1);
    check("arst_aec", o_aec, 1);
    check("arst_cycle", o_cycle, 1);
    check("arst_raster", o_raster, 0);
    check("arst_phi2", o_phi2_acc, 0);
    check("arst_badline", o_badline, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vic_bus_scheduler.md
Name: vic_bus_scheduler

Overview:
Cycle scheduler for the VIC-II memory bus. It runs the PAL 6569 raster timing and tracks the current cycle and raster line. It decides which memory access the video core makes in each half-cycle: refresh, character pointer (c), graphics (g), sprite pointer (p) or sprite data (s). It drives BA/AEC so the CPU and the video datapath share the bus, and it feeds the sync/pixel logic.

Parameters:
CYCLES_PER_LINE, 63, system cycles per raster line; the cycle counter runs 1..CYCLES_PER_LINE.
LINES_PER_FRAME, 312, raster lines per frame; the raster counter runs 0..LINES_PER_FRAME-1.
FIRST_DMA_LINE, 48, first line on which a badline can occur.
LAST_DMA_LINE, 247, last line on which a badline can occur.
BA_LEAD, 3, number of cycles BA goes low before the first VIC phi2 steal.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous reset, active-low.
i_cycle_tick  in  1  one-clk pulse per 1 MHz bus cycle; advances the schedule.
i_den  in  1  display enable (register $D011 bit 4).
i_yscroll  in  3  vertical fine scroll.
i_sprite_dma  in  8  per-sprite DMA active flags.
o_cycle  out  6  current cycle, 1..63.
o_raster  out  9  current raster line, 0..311.
o_badline  out  1  current line is a badline.
o_ba  out  1  bus available; 0 means the VIC is requesting the bus.
o_aec  out  1  0 when the VIC owns phi2 of the current cycle.
o_phi1_acc  out  3  VIC phi1 access type.
o_phi2_acc  out  3  VIC phi2 access type.
o_sprite_idx  out  3  sprite addressed by the current p/s access.
o_frame_start  out  1  one-clk pulse when raster 0, cycle 1 begins.

Behaviour:
- Access encoding: 0 IDLE/CPU, 1 REFRESH, 2 CHAR, 3 GFX, 4 SPR_PTR, 5 SPR_DATA.
- Reset (reset=0, asynchronous):
  - cycle=1, raster=0, den_latch=0, display_state=0.
  - o_ba=1, o_aec=1, both access outputs=0, o_badline=0, o_frame_start=0, o_sprite_idx=0.
  - The access outputs stay 0 until the first tick.
- All outputs are registered. On the clk edge that samples i_cycle_tick=1, the counters advance and the outputs for the new cycle appear on that same edge. Latency from tick to outputs is 1 clk. Outputs hold between ticks.
- Cycle wrap: after cycle 63, cycle goes to 1 and raster increments. After raster 311, raster goes to 0 and o_frame_start pulses for exactly 1 clk.
- den_latch:
  - Set if i_den=1 at any tick while raster==FIRST_DMA_LINE.
  - Cleared when raster wraps to 0.
- badline = den_latch && FIRST_DMA_LINE<=raster<=LAST_DMA_LINE && raster[2:0]==i_yscroll. It is re-evaluated every tick, so a yscroll change mid-line takes effect on the next tick.
- display_state:
  - Set on any badline cycle.
  - Cleared when raster>LAST_DMA_LINE or at frame wrap.
- Sprite p-cycles P(n): sprite0=58, 1=60, 2=62, 3=1, 4=3, 5=5, 6=7, 7=9.
- phi1 access by cycle:
  - Cycle P(n): SPR_PTR, always issued.
  - Cycle P(n)+1: SPR_DATA if i_sprite_dma[n], else IDLE.
  - Cycles 11..15: REFRESH.
  - Cycles 16..55: GFX if display_state, else IDLE.
  - All other cycles: IDLE.
- phi2 access by cycle:
  - Cycles 15..54 on a badline: CHAR.
  - Cycles P(n) and P(n)+1 with i_sprite_dma[n]=1: SPR_DATA.
  - All other cycles: 0, CPU owns phi2.
- o_sprite_idx = n during P(n) and P(n)+1; otherwise 0.
- o_aec = 0 exactly when o_phi2_acc != 0.
- o_ba:
  - 0 if any phi2 steal is scheduled within cycles c..c+BA_LEAD, with cycles taken modulo 63 and wrapping into the next line.
  - On a badline, BA is low on cycles 12..54.
  - For sprite n with DMA, BA is low on cycles P-3..P+1. Sprite 3 therefore pulls BA low on cycles 61..63 of the previous line.
- The sprite windows for sprites 0/1 and 1/2 overlap; the result is the OR of all windows, giving one continuous low period with no glitch.
- If i_sprite_dma[n] changes inside its window, the flag is sampled at each tick; there is no hold.
- Asynchronous reset mid-line returns the block to the reset state immediately, independent of clk.

Test Plan:
1. Assert reset for 5 clk, then release with no ticks -> o_cycle=1, o_raster=0, o_ba=1, o_aec=1, both access outputs=0.
2. Set den=1 on line 48 and yscroll=0, run to line 48 -> o_badline=1. o_ba=0 on cycles 12..54 exactly. o_phi2_acc=2 and o_aec=0 on cycles 15..54. o_phi1_acc=1 on 11..15 and 3 on 16..55. Then line 49 -> o_ba=1 on all cycles.
3. Set i_sprite_dma=8'h01 on a non-badline -> o_ba=0 on cycles 55..59. On cycle 58, phi1=4 and phi2=5. On cycle 59, phi1=5 and phi2=5. o_sprite_idx=0 on both cycles.
4. Set i_sprite_dma=8'h08 -> o_ba=0 on cycles 61,62,63 of line k and cycles 1,2 of line k+1. phi2=5 on cycles 1 and 2, with o_sprite_idx=3.
5. Hold den=0 throughout line 48 and set den=1 afterwards -> no badline anywhere in the frame. Then tick from raster 311, cycle 63 -> raster 0, cycle 1, o_frame_start high for 1 clk.
6. Assert reset during cycle 30 of a badline -> o_ba=1, o_aec=1, o_cycle=1 immediately, before the next clk edge.
